// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and data access, data first.
// Define ARB_STARVE_GUARD_EN to add the fetch starvation guard.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_re,
    input  logic [3:0]  dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        dm_lock,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_re,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    logic                   w_data_req;
    logic                   w_data_win;
    logic                   w_fetch_win;
    logic                   w_starved;
    logic                   w_last_v;
    logic                   w_last_f;
    logic                   r_lock;
    logic [MEM_LATENCY-1:0] r_pv;
    logic [MEM_LATENCY-1:0] r_pf;

    assign w_data_req = dm_re | (|dm_we);

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] r_starve;

    assign w_starved = (r_starve == 4'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 4'd0;
        end else if (clk_en) begin
            if (!if_req || w_fetch_win)
                r_starve <= 4'd0;
            else if (!w_starved)
                r_starve <= r_starve + 4'd1;
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    // A held lock blocks fetch outright, even a starved one.
    always_comb begin
        w_data_win  = 1'b0;
        w_fetch_win = 1'b0;
        if (clk_en) begin
            if (r_lock)
                w_data_win = w_data_req;
            else if (w_starved && if_req)
                w_fetch_win = 1'b1;
            else if (w_data_req)
                w_data_win = 1'b1;
            else
                w_fetch_win = if_req;
        end
    end

    assign if_gnt    = w_fetch_win;
    assign dm_gnt    = w_data_win;
    assign mem_re    = w_data_win ? dm_re : w_fetch_win;
    assign mem_we    = w_data_win ? dm_we : 4'h0;
    assign mem_wdata = w_data_win ? dm_wdata : 32'h0;
    assign mem_addr  = w_data_win  ? dm_addr :
                       w_fetch_win ? if_addr : 32'h0;

    assign w_last_v = r_pv[MEM_LATENCY-1];
    assign w_last_f = r_pf[MEM_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
            r_pv   <= '0;
            r_pf   <= '0;
        end else if (clk_en) begin
            r_lock <= dm_lock & w_data_win;
            for (int i = MEM_LATENCY - 1; i > 0; i--) begin
                r_pv[i] <= r_pv[i-1];
                r_pf[i] <= r_pf[i-1];
            end
            r_pv[0] <= mem_re;
            r_pf[0] <= w_fetch_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= 32'h0;
            dm_rdata  <= 32'h0;
        end else if (clk_en) begin
            if_rvalid <= w_last_v & w_last_f;
            dm_rvalid <= w_last_v & ~w_last_f;
            if (w_last_v && w_last_f)
                if_rdata <= mem_rdata;
            if (w_last_v && !w_last_f)
                dm_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter against a transaction-level
// reference model with a latency-accurate memory attached.
module tb_mem_port_arbiter;
    localparam int L  = 2;
    localparam int SL = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_re = 1'b0;
    logic [3:0]  dm_we = 4'h0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic        dm_lock = 1'b0;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_re;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_lock(dm_lock), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] f_init(input int i);
        if (i == 64)
            return 32'hDEADBEEF;
        return {8'(i), 8'hC3, 8'(i * 7), 8'h5A};
    endfunction

    // Memory: reads return pre-write contents L enabled cycles after issue.
    logic [31:0] mem [256];
    logic [31:0] mpipe [L];
    assign mem_rdata = mpipe[L-1];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= f_init(i);
        end else if (clk_en) begin
            for (int i = L - 1; i > 0; i--)
                mpipe[i] <= mpipe[i-1];
            mpipe[0] <= mem_re ? mem[mem_addr[9:2]] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (mem_we[b])
                    mem[mem_addr[9:2]][b*8+:8] <= mem_wdata[b*8+:8];
        end
    end

    typedef struct {
        int          due;
        bit          fetch;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] sm [256];
    int          m_starve;
    bit          m_lock;
    int          ecnt;
    bit          m_fw;
    bit          m_dw;
    bit          e_ifv;
    bit          e_dmv;
    logic [31:0] e_ifd;
    logic [31:0] e_dmd;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_lock   = 1'b0;
        m_starve = 0;
        ecnt     = 0;
        e_ifv    = 1'b0;
        e_dmv    = 1'b0;
        e_ifd    = 32'h0;
        e_dmd    = 32'h0;
        for (int i = 0; i < 256; i++)
            sm[i] = f_init(i);
    endtask

    task automatic chk_rsp();
        chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
        chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dmv));
        chk("if_rdata", if_rdata, e_ifd);
        chk("dm_rdata", dm_rdata, e_dmd);
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic do_reset();
        if_req = 1'b0; dm_re = 1'b0; dm_we = 4'h0; dm_lock = 1'b0;
        clk_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_rsp();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit ir, input logic [31:0] ia,
                         input bit dre, input logic [3:0] dwe,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input bit lk, input bit ce);
        bit dreq;
        int idx;
        if_req = ir; if_addr = ia; dm_re = dre; dm_we = dwe;
        dm_addr = da; dm_wdata = dwd; dm_lock = lk; clk_en = ce;
        dreq = dre || (dwe != 4'h0);
        m_fw = 1'b0;
        m_dw = 1'b0;
        if (ce) begin
            if (m_lock)
                m_dw = dreq;
            else if (GUARD && m_starve == SL && ir)
                m_fw = 1'b1;
            else if (dreq)
                m_dw = 1'b1;
            else
                m_fw = ir;
        end
        #2;
        chk("if_gnt", 32'(if_gnt), 32'(m_fw));
        chk("dm_gnt", 32'(dm_gnt), 32'(m_dw));
        chk("mem_re", 32'(mem_re), 32'(m_dw ? dre : m_fw));
        chk("mem_we", 32'(mem_we), 32'(m_dw ? dwe : 4'h0));
        chk("mem_addr", mem_addr, m_dw ? da : (m_fw ? ia : 32'h0));
        chk("mem_wdata", mem_wdata, m_dw ? dwd : 32'h0);
        @(posedge clk);
        #1;
        if (ce) begin
            ecnt++;
            idx = m_dw ? int'(da[9:2]) : int'(ia[9:2]);
            if ((m_dw && dre) || m_fw)
                q.push_back('{ecnt + L, m_fw, sm[idx]});
            if (m_dw)
                for (int b = 0; b < 4; b++)
                    if (dwe[b])
                        sm[idx][b*8+:8] = dwd[b*8+:8];
            m_lock = lk && m_dw;
            if (!ir || m_fw)
                m_starve = 0;
            else if (m_starve < SL)
                m_starve++;
            e_ifv = 1'b0;
            e_dmv = 1'b0;
            if (q.size() > 0 && q[0].due == ecnt) begin
                if (q[0].fetch) begin
                    e_ifv = 1'b1;
                    e_ifd = q[0].data;
                end else begin
                    e_dmv = 1'b1;
                    e_dmd = q[0].data;
                end
                void'(q.pop_front());
            end
        end
        chk_rsp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            apply(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    endtask

    initial begin
        bit          cir;
        logic [31:0] cia;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // fetch only
        apply(1, 32'h100, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        idle(4);

        // collision: fetch and data read both held
        for (int i = 0; i < 11; i++)
            apply(1, 32'h40, 1, 4'h0, 32'h80, 32'h0, 0, 1);
        idle(4);

        // split store pair locked while fetch is starving
        for (int i = 0; i < 3; i++)
            apply(1, 32'h20, 0, 4'hC, 32'h200, 32'h11223344, 0, 1);
        apply(1, 32'h20, 0, 4'hC, 32'h202, 32'hAABB0000, 1, 1);
        apply(1, 32'h20, 0, 4'h3, 32'h204, 32'h0000CCDD, 0, 1);
        apply(1, 32'h20, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        idle(4);

        // interleaved fetch/data/fetch reads, back to back
        apply(1, 32'h10, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        apply(0, 32'h0, 1, 4'h0, 32'h200, 32'h0, 0, 1);
        apply(1, 32'h18, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        idle(4);

        // combined read+write returns old data, next read sees new
        apply(0, 32'h0, 1, 4'hF, 32'h30, 32'hCAFEF00D, 0, 1);
        apply(0, 32'h0, 1, 4'h0, 32'h30, 32'h0, 0, 1);
        idle(4);

        // freeze mid-flight
        apply(1, 32'h24, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        apply(0, 32'h0, 1, 4'h0, 32'h34, 32'h0, 0, 1);
        for (int i = 0; i < 3; i++)
            apply(1, 32'h28, 1, 4'h0, 32'h38, 32'h0, 0, 0);
        idle(5);

        // reset with two reads in flight
        apply(1, 32'h44, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        apply(0, 32'h0, 1, 4'h0, 32'h48, 32'h0, 0, 1);
        do_reset();
        idle(5);

        // random traffic, fetch request held until granted
        cir = 1'b0;
        cia = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!cir && $urandom_range(0, 2) != 0) begin
                cir = 1'b1;
                cia = {22'h0, 8'($urandom), 2'b00};
            end
            apply(cir, cia, $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                  {22'h0, 10'($urandom)}, $urandom,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0);
            if (m_fw)
                cir = 1'b0;
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
